// File: rtl/lane_scroller.sv
// lane_scroller: obstacle-lane engine for the Frogger playfield.
// Holds a ROWS x COLS obstacle bitmap. An internal tick generator, whose
// period depends on the game level, rotates the selected lanes. Each lane is
// a lane_scroller_lane instance that owns its own row register.
// Ports:
//   clk        system clock
//   reset      asynchronous active-high full reset
//   resetGame  synchronous restart (bitmap, tick counter and phase)
//   pause      freezes the lanes and the tick counter
//   level      one-hot level select (0001/0010/0100/1000)
//   obs        registered obstacle bitmap, [ROWS-1:0][COLS-1:0]
//   step       1-cycle pulse in the cycle obs shows a fresh scroll

// One lane: a COLS-bit row that wraps one cell per qualifying tick.
// Ports: clk/reset, restart (sync reload), tick, phase (odd/even tick),
//        row (current contents), moved (row rotates on this edge).
module lane_scroller_lane #(
  parameter int              COLS = 8,
  parameter bit              MOVE = 1'b0,
  parameter bit              DIR  = 1'b0,
  parameter bit              SLOW = 1'b0,
  parameter logic [COLS-1:0] INIT = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            restart,
  input  logic            tick,
  input  logic            phase,
  output logic [COLS-1:0] row,
  output logic            moved
);

  // Slow lanes only advance on the ticks where phase is already 1
  // (2nd, 4th, ... tick after a restart).
  assign moved = tick & MOVE & (~SLOW | phase);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        row <= INIT;
    else if (restart) row <= INIT;
    else if (moved)   row <= DIR ? {row[0], row[COLS-1:1]}
                                 : {row[COLS-2:0], row[COLS-1]};
  end

endmodule

module lane_scroller #(
  parameter int                   ROWS         = 8,
  parameter int                   COLS         = 8,
  parameter int                   PW           = 26,
  parameter int                   PERIOD_L1    = 12_500_000,
  parameter int                   PERIOD_L2    = 8_333_333,
  parameter int                   PERIOD_L3    = 6_250_000,
  parameter int                   PERIOD_L4    = 5_000_000,
  parameter logic [ROWS-1:0]      MOVE_MASK    = 8'b0111_1110,
  parameter logic [ROWS-1:0]      DIR_MASK     = 8'b0101_0100,
  parameter logic [ROWS-1:0]      SLOW_MASK    = 8'b0000_0000,
  parameter logic [ROWS*COLS-1:0] INIT_PATTERN = 64'h00_36_66_60_C3_60_63_00
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           resetGame,
  input  logic                           pause,
  input  logic [3:0]                     level,
  output logic [ROWS-1:0][COLS-1:0]      obs,
  output logic                           step
);

  logic [PW-1:0]   cnt;
  logic [PW-1:0]   period_m1;
  logic            phase;
  logic            tick;
  logic [ROWS-1:0] moved;

  // Terminal count per level; non-one-hot levels fall back to level 1.
  always_comb begin
    period_m1 = PW'(PERIOD_L1 - 1);
    case (level)
      4'b0010: period_m1 = PW'(PERIOD_L2 - 1);
      4'b0100: period_m1 = PW'(PERIOD_L3 - 1);
      4'b1000: period_m1 = PW'(PERIOD_L4 - 1);
      default: period_m1 = PW'(PERIOD_L1 - 1);
    endcase
  end

  // >= rather than == so that switching to a shorter period while the
  // counter is already past the new terminal count fires on the next edge.
  assign tick = (cnt >= period_m1) & ~pause;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      phase <= 1'b0;
      step  <= 1'b0;
    end else if (resetGame) begin
      cnt   <= '0;
      phase <= 1'b0;
      step  <= 1'b0;
    end else begin
      // moved is all-zero while paused, so step drops during pause too.
      step <= |moved;
      if (tick) begin
        cnt   <= '0;
        phase <= ~phase;
      end else if (!pause) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    lane_scroller_lane #(
      .COLS (COLS),
      .MOVE (MOVE_MASK[r]),
      .DIR  (DIR_MASK[r]),
      .SLOW (SLOW_MASK[r]),
      .INIT (INIT_PATTERN[r*COLS +: COLS])
    ) u_lane (
      .clk     (clk),
      .reset   (reset),
      .restart (resetGame),
      .tick    (tick),
      .phase   (phase),
      .row     (obs[r]),
      .moved   (moved[r])
    );
  end

endmodule

// File: tb/tb_lane_scroller.sv
// Bench for lane_scroller with short tick periods (4/3/2/1) and lane 3 slow.
// A behavioural model of the playfield (byte-wide rows, integer tick count)
// is compared against the DUT on every falling edge; directed literal checks
// pin the model to hand-computed values.
module tb_lane_scroller;

  localparam logic [7:0]  MOVE = 8'b0111_1110;
  localparam logic [7:0]  DIR  = 8'b0101_0100;
  localparam logic [7:0]  SLOW = 8'b0000_1000;
  localparam logic [63:0] INIT = 64'h00_36_66_60_C3_60_63_00;

  logic            clk;
  logic            reset;
  logic            resetGame;
  logic            pause;
  logic [3:0]      level;
  logic [7:0][7:0] obs;
  logic            step;

  int tests  = 0;
  int errors = 0;

  lane_scroller #(
    .PERIOD_L1 (4),
    .PERIOD_L2 (3),
    .PERIOD_L3 (2),
    .PERIOD_L4 (1),
    .SLOW_MASK (SLOW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .resetGame (resetGame),
    .pause     (pause),
    .level     (level),
    .obs       (obs),
    .step      (step)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] m_row [8];
  int         m_cnt;
  logic       m_phase;
  logic       m_step;

  function automatic int period_of(input logic [3:0] l);
    case (l)
      4'b0010: return 3;
      4'b0100: return 2;
      4'b1000: return 1;
      default: return 4;
    endcase
  endfunction

  function automatic logic [7:0] rol(input logic [7:0] v);
    return 8'((int'(v) * 2) % 256 + int'(v) / 128);
  endfunction

  function automatic logic [7:0] ror(input logic [7:0] v);
    return 8'(int'(v) / 2 + (int'(v) % 2) * 128);
  endfunction

  function automatic bit lane_moves(input int r, input logic ph);
    return MOVE[r] && (!SLOW[r] || ph);
  endfunction

  function automatic bit any_moves(input logic ph);
    bit a = 0;
    for (int r = 0; r < 8; r++) if (lane_moves(r, ph)) a = 1;
    return a;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset || resetGame) begin
      for (int r = 0; r < 8; r++) m_row[r] <= INIT[r*8 +: 8];
      m_cnt   <= 0;
      m_phase <= 1'b0;
      m_step  <= 1'b0;
    end else if (pause) begin
      m_step <= 1'b0;
    end else if (m_cnt + 1 >= period_of(level)) begin
      for (int r = 0; r < 8; r++)
        if (lane_moves(r, m_phase)) m_row[r] <= DIR[r] ? ror(m_row[r]) : rol(m_row[r]);
      m_cnt   <= 0;
      m_phase <= ~m_phase;
      m_step  <= any_moves(m_phase);
    end else begin
      m_cnt  <= m_cnt + 1;
      m_step <= 1'b0;
    end
  end

  function automatic logic [63:0] model_obs();
    logic [63:0] v;
    for (int r = 0; r < 8; r++) v[r*8 +: 8] = m_row[r];
    return v;
  endfunction

  always @(negedge clk) begin
    chk("obs_vs_model", obs, model_obs());
    chk("step_vs_model", 64'(step), 64'(m_step));
  end

  // ---------------- directed stimulus ----------------
  int nsteps, first_step, last_step, n;

  initial begin
    reset = 1'b0; resetGame = 1'b0; pause = 1'b0; level = 4'b0001;

    // T1: async reset between edges
    #1 reset = 1'b1;
    #1;
    chk("t1_obs", obs, 64'h0036_6660_C360_6300);
    chk("t1_step", 64'(step), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // T2: period 1, single edge
    level = 4'b1000;
    @(negedge clk);
    chk("t2_row1", 64'(obs[1]), 64'hC6);
    chk("t2_row2", 64'(obs[2]), 64'h30);
    chk("t2_row0", 64'(obs[0]), 64'h00);
    chk("t2_row7", 64'(obs[7]), 64'h00);
    chk("t5_row3_tick1", 64'(obs[3]), 64'hC3);
    chk("t2_step", 64'(step), 64'd1);

    // T5: second tick moves the slow lane
    @(negedge clk);
    chk("t5_row3_tick2", 64'(obs[3]), 64'h87);
    chk("t5_row1_tick2", 64'(obs[1]), 64'h8D);

    // T3: restart, then level 1 for 12 cycles
    resetGame = 1'b1;
    @(negedge clk);
    chk("t3_restart_obs", obs, INIT);
    chk("t3_restart_step", 64'(step), 64'd0);
    resetGame = 1'b0; level = 4'b0001;
    nsteps = 0; first_step = 0; last_step = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (step) begin
        nsteps++;
        if (first_step == 0) first_step = i;
        last_step = i;
      end
    end
    chk("t3_nsteps", 64'(nsteps), 64'd3);
    chk("t3_first", 64'(first_step), 64'd4);
    chk("t3_last", 64'(last_step), 64'd12);
    chk("t3_row1", 64'(obs[1]), 64'h1B);
    chk("t3_row3", 64'(obs[3]), 64'h87);

    // T4: pause mid-count (count at 2 of 4)
    repeat (2) @(negedge clk);
    pause = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t4_pause_row1", 64'(obs[1]), 64'h1B);
      chk("t4_pause_step", 64'(step), 64'd0);
    end
    pause = 1'b0;
    n = 0;
    while (n < 10) begin
      @(negedge clk);
      n++;
      if (step) break;
    end
    chk("t4_resume_edges", 64'(n), 64'd2);
    chk("t4_row1", 64'(obs[1]), 64'h36);

    // Shorter period mid-count fires on the next edge
    repeat (2) @(negedge clk);
    level = 4'b0100;
    @(negedge clk);
    chk("lvl_change_step", 64'(step), 64'd1);

    // T6: restart after 5 ticks, then async reset mid-count
    level = 4'b1000;
    repeat (5) @(negedge clk);
    resetGame = 1'b1;
    @(negedge clk);
    chk("t6_restart_obs", obs, INIT);
    chk("t6_restart_step", 64'(step), 64'd0);
    resetGame = 1'b0;
    @(negedge clk);
    chk("t6_row1", 64'(obs[1]), 64'hC6);
    chk("t6_row3_phase0", 64'(obs[3]), 64'hC3);
    level = 4'b0001;
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("t6_async_obs", obs, INIT);
    chk("t6_async_step", 64'(step), 64'd0);
    #1 reset = 1'b0;
    repeat (9) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
